// File: rtl/spike_mon_pkg.sv
// Shared types and default widths for the spike window monitor.
package spike_mon_pkg;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_WIN_W   = 8;
  localparam int DEF_STATE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mon_state_t;

  typedef struct packed {
    logic [DEF_CNT_W-1:0]   count;
    logic [DEF_STATE_W-1:0] peak;
  } result_t;

endpackage

// File: rtl/spike_window_monitor_result_buffer.sv
// One-deep valid/ready holding register; a load that finds it full is dropped
// and raises a sticky overrun flag.
module result_buffer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              overrun
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic              overrun_reg;
  logic              slot_free;

  // A consume on the same edge frees the slot for an incoming record.
  assign slot_free = !valid_reg || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg   <= 1'b0;
      data_reg    <= '0;
      overrun_reg <= 1'b0;
    end else if (load && slot_free) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
    end else if (load) begin
      overrun_reg <= 1'b1;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign overrun   = overrun_reg;

endmodule

// File: rtl/spike_window_monitor.sv
// Counts spikes and tracks peak membrane state over programmable windows,
// handing each window's record to a one-deep output buffer.
module spike_window_monitor
  import spike_mon_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int WIN_W   = DEF_WIN_W,
  parameter int STATE_W = DEF_STATE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [WIN_W-1:0]   window_len,
  input  logic               spike_in,
  input  logic [STATE_W-1:0] state_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   out_count,
  output logic [STATE_W-1:0] out_peak,
  output logic               overrun,
  output logic               busy
);

  mon_state_t         state_reg, state_next;
  logic [WIN_W-1:0]   win_len_reg;
  logic [WIN_W-1:0]   tick_reg;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [STATE_W-1:0] peak_reg, peak_next;
  logic               start, sampling, last;
  logic [CNT_W+STATE_W-1:0] buf_data;

  assign start    = (state_reg == IDLE) && enable && (window_len != '0);
  assign sampling = (state_reg == RUN) && enable;
  assign last     = (tick_reg == win_len_reg - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (!enable)                          state_next = IDLE;
        else if (last && window_len == '0)    state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == RUN);
  end

  // Results include the sample taken on the closing edge.
  always_comb begin
    count_next = count_reg;
    if (spike_in && count_reg != '1) count_next = count_reg + 1'b1;
    peak_next = (state_in > peak_reg) ? state_in : peak_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_len_reg <= '0;
      tick_reg    <= '0;
      count_reg   <= '0;
      peak_reg    <= '0;
    end else if (start || (sampling && last)) begin
      win_len_reg <= window_len;
      tick_reg    <= '0;
      count_reg   <= '0;
      peak_reg    <= '0;
    end else if (sampling) begin
      tick_reg  <= tick_reg + 1'b1;
      count_reg <= count_next;
      peak_reg  <= peak_next;
    end
  end

  assign buf_data = {count_next, peak_next};

  result_buffer #(
    .DATA_W(CNT_W + STATE_W)
  ) u_result_buffer (
    .clk      (clk),
    .rst      (rst),
    .load     (sampling && last),
    .load_data(buf_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data ({out_count, out_peak}),
    .overrun  (overrun)
  );

endmodule

// File: tb/tb_spike_window_monitor.sv
// Self-checking bench: table of isolated windows plus hand sequences for
// backpressure, back-to-back delivery, abort and reset corner cases.
module tb_spike_window_monitor;
  import spike_mon_pkg::*;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] window_len;
  logic       spike_in;
  logic [7:0] state_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_count;
  logic [7:0] out_peak;
  logic       overrun;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  result_t sb[$];

  typedef struct {
    int len;
    int spike_mode;
    int state_mode;
    int state_c;
    int exp_count;
    int exp_peak;
  } vec_t;

  spike_window_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .window_len(window_len),
    .spike_in  (spike_in),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_peak  (out_peak),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Scoreboard: every accepted record is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_record: got count=%0d peak=%0d, expected none",
                 out_count, out_peak);
      end else begin
        result_t e;
        e = sb.pop_front();
        check("rec_count", int'(out_count), int'(e.count));
        check("rec_peak", int'(out_peak), int'(e.peak));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int c, input int p);
    result_t e;
    e.count = 8'(c);
    e.peak  = 8'(p);
    sb.push_back(e);
  endtask

  function automatic logic spike_of(input int mode, input int i);
    case (mode)
      1:       return 1'b1;
      2:       return (i % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] state_of(input int mode, input int c, input int i);
    case (mode)
      1:       return 8'(i);
      2:       return 8'(255 - i);
      3:       return 8'(i * 3);
      default: return 8'(c);
    endcase
  endfunction

  // Starts from IDLE, runs one window and returns to IDLE on its last sample.
  task automatic run_window(input int len, input int sm, input int tm, input int c);
    enable = 1'b1;
    window_len = 8'(len);
    spike_in = 1'b0;
    step();
    for (int i = 0; i < len; i++) begin
      spike_in = spike_of(sm, i);
      state_in = state_of(tm, c, i);
      window_len = (i == len - 1) ? 8'd0 : 8'(len);
      step();
    end
    enable = 1'b0;
    spike_in = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{len: 1,   spike_mode: 1, state_mode: 0, state_c: 7, exp_count: 1,   exp_peak: 7};
    vecs[1] = '{len: 255, spike_mode: 1, state_mode: 1, state_c: 0, exp_count: 255, exp_peak: 254};
    vecs[2] = '{len: 8,   spike_mode: 0, state_mode: 2, state_c: 0, exp_count: 0,   exp_peak: 255};
    vecs[3] = '{len: 16,  spike_mode: 2, state_mode: 3, state_c: 0, exp_count: 8,   exp_peak: 45};
    vecs[4] = '{len: 2,   spike_mode: 1, state_mode: 0, state_c: 0, exp_count: 2,   exp_peak: 0};

    rst = 1'b1; enable = 1'b0; window_len = 8'd0; spike_in = 1'b0;
    state_in = 8'd0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check("reset_valid", int'(out_valid), 0);
    check("reset_count", int'(out_count), 0);
    check("reset_peak", int'(out_peak), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_busy", int'(busy), 0);

    // Basic window: spikes on samples 2,5,9; ramp with a 200 spike at sample 4.
    push_exp(3, 200);
    enable = 1'b1; window_len = 8'd10;
    step();
    check("basic_busy", int'(busy), 1);
    for (int i = 0; i < 10; i++) begin
      spike_in = (i == 2 || i == 5 || i == 9);
      state_in = (i == 4) ? 8'd200 : 8'(i);
      window_len = (i == 9) ? 8'd0 : 8'd10;
      if (i == 9) check("basic_valid_before_last", int'(out_valid), 0);
      step();
    end
    enable = 1'b0; spike_in = 1'b0;
    check("basic_valid_latency", int'(out_valid), 1);
    step();
    check("basic_valid_drop", int'(out_valid), 0);

    // Backpressure: second window end overruns while record 1 is held.
    out_ready = 1'b0; enable = 1'b1; window_len = 8'd4;
    step();
    for (int i = 0; i < 8; i++) begin
      spike_in = 1'b1; state_in = 8'd5;
      window_len = (i == 7) ? 8'd0 : 8'd4;
      step();
      if (i == 3) check("bp_first_valid", int'(out_valid), 1);
      if (i == 5) check("bp_hold_count", int'(out_count), 4);
      if (i == 6) check("bp_no_overrun_yet", int'(overrun), 0);
    end
    enable = 1'b0; spike_in = 1'b0;
    check("bp_overrun", int'(overrun), 1);
    check("bp_kept_count", int'(out_count), 4);
    check("bp_busy", int'(busy), 0);
    push_exp(4, 5);
    step();
    check("bp_overrun_sticky", int'(overrun), 1);
    out_ready = 1'b1;
    step();
    check("bp_drained", int'(out_valid), 0);
    check("bp_overrun_after_drain", int'(overrun), 1);
    rst = 1'b1; step(); rst = 1'b0;
    check("bp_overrun_cleared", int'(overrun), 0);

    // Back-to-back: ready only on window-end cycles, so consume and load coincide.
    out_ready = 1'b0; enable = 1'b1; window_len = 8'd3;
    step();
    for (int j = 0; j < 9; j++) begin
      spike_in = (j % 3) < (j / 3 + 1);
      state_in = 8'(10 * (j / 3) + j % 3);
      window_len = (j == 8) ? 8'd0 : 8'd3;
      out_ready = (j == 5 || j == 8);
      if (j % 3 == 2) push_exp(j / 3 + 1, 10 * (j / 3) + 2);
      step();
      if (j >= 2) check("b2b_valid_held", int'(out_valid), 1);
    end
    enable = 1'b0; spike_in = 1'b0; out_ready = 1'b1;
    step();
    check("b2b_final_drop", int'(out_valid), 0);
    check("b2b_overrun", int'(overrun), 0);

    // Abort at tick 5 of a 10-cycle window, then zero-length request.
    enable = 1'b1; window_len = 8'd10;
    step();
    for (int i = 0; i < 5; i++) begin
      spike_in = 1'b1; state_in = 8'(i);
      step();
    end
    enable = 1'b0;
    step();
    check("abort_busy", int'(busy), 0);
    step(); step();
    check("abort_valid", int'(out_valid), 0);
    check("abort_overrun", int'(overrun), 0);
    enable = 1'b1; window_len = 8'd0;
    step(); step(); step();
    check("zero_len_busy", int'(busy), 0);
    check("zero_len_valid", int'(out_valid), 0);
    enable = 1'b0;

    // Reset with a pending record and a window at tick 3.
    out_ready = 1'b0; enable = 1'b1; window_len = 8'd2;
    step();
    for (int i = 0; i < 5; i++) begin
      spike_in = 1'b1; state_in = 8'd9;
      window_len = 8'd10;
      step();
    end
    check("rstmid_pre_valid", int'(out_valid), 1);
    check("rstmid_pre_busy", int'(busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0; enable = 1'b0; spike_in = 1'b0; out_ready = 1'b1;
    check("rstmid_valid", int'(out_valid), 0);
    check("rstmid_overrun", int'(overrun), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_count", int'(out_count), 0);
    check("rstmid_peak", int'(out_peak), 0);

    // Table of isolated windows.
    for (int v = 0; v < 5; v++) begin
      push_exp(vecs[v].exp_count, vecs[v].exp_peak);
      run_window(vecs[v].len, vecs[v].spike_mode, vecs[v].state_mode, vecs[v].state_c);
      step(); step();
      check("tbl_valid_clear", int'(out_valid), 0);
      check("tbl_busy", int'(busy), 0);
      check("tbl_overrun", int'(overrun), 0);
    end

    check("sb_leftover", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
